// File: rtl/spi_pkg.sv
// Shared definitions for the APB-SPI master: mode encodings and the baud divisor
// function that both the baud generator and the slave-select stage must agree on.
package spi_pkg;

    localparam logic [1:0] SPI_RUN   = 2'b00;
    localparam logic [1:0] SPI_WAIT  = 2'b01;
    localparam int         SPI_DIV_W = 12;

    // (sppr+1) * 2^(spr+1): 2 .. 2048, always fits in SPI_DIV_W bits
    function automatic logic [SPI_DIV_W-1:0] spi_baud_divisor(input logic [2:0] sppr,
                                                              input logic [2:0] spr);
        logic [SPI_DIV_W-1:0] base;
        logic [3:0]           shamt;
        base  = SPI_DIV_W'(sppr) + SPI_DIV_W'(1);
        shamt = {1'b0, spr} + 4'd1;
        return base << shamt;
    endfunction

endpackage

// File: rtl/spi_baud_generator.sv
// SPI serial-clock generator: divides PCLK by the prescaler-derived divisor while
// the slave is selected and flags each SCLK edge as a sample or shift edge.
module spi_baud_generator
    import spi_pkg::*;
(
    input  logic                 PCLK,
    input  logic                 PRESET_n,
    input  logic [1:0]           spi_mode_i,
    input  logic                 spiswai_i,
    input  logic [2:0]           sppr_i,
    input  logic [2:0]           spr_i,
    input  logic                 cpol_i,
    input  logic                 cpha_i,
    input  logic                 ss_i,
    output logic                 sclk_o,
    output logic                 receive_sclk_o,
    output logic                 send_sclk_o,
    output logic [SPI_DIV_W-1:0] BaudRateDivisor_o
);

    logic [SPI_DIV_W-1:0] count;
    logic [SPI_DIV_W-1:0] half;
    logic                 enable;
    logic                 tc;
    logic                 leading;
    logic                 is_sample;

    always_comb begin
        BaudRateDivisor_o = spi_baud_divisor(sppr_i, spr_i);
        half              = BaudRateDivisor_o >> 1;
        enable            = !ss_i && ((spi_mode_i == SPI_RUN) ||
                                      (spi_mode_i == SPI_WAIT && !spiswai_i));
        // >= rather than == so a divisor shrinking mid-count cannot strand the counter
        tc                = count >= (half - SPI_DIV_W'(1));
        leading           = (sclk_o == cpol_i);
        is_sample         = leading ^ cpha_i;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET_n || !enable) begin
            count          <= '0;
            sclk_o         <= cpol_i;
            receive_sclk_o <= 1'b0;
            send_sclk_o    <= 1'b0;
        end else if (tc) begin
            count          <= '0;
            sclk_o         <= ~sclk_o;
            receive_sclk_o <= is_sample;
            send_sclk_o    <= !is_sample;
        end else begin
            count          <= count + SPI_DIV_W'(1);
            receive_sclk_o <= 1'b0;
            send_sclk_o    <= 1'b0;
        end
    end

endmodule

// File: doc/spi_baud_generator.md
# spi_baud_generator

SPI serial-clock generator for the APB-SPI master. Computes the baud-rate divisor from the prescaler fields, drives `BaudRateDivisor_o` to the slave-select stage, and produces `sclk_o` while that stage holds `ss_i` low. It also emits one-cycle sample/shift strobes that tell the shift register when to capture MISO and when to drive MOSI.

## Interface
Parameters:
- none (divisor width fixed at 12; the constant lives in the package)

Ports:
- `PCLK` in 1 — system clock; only clock in the block
- `PRESET_n` in 1 — reset; synchronous, active-low
- `spi_mode_i` in 2 — 00 run, 01 wait, 1x stop
- `spiswai_i` in 1 — 1 stops the SPI clock in wait mode
- `sppr_i` in 3 — baud prescaler select
- `spr_i` in 3 — baud rate select
- `cpol_i` in 1 — clock idle level
- `cpha_i` in 1 — clock phase
- `ss_i` in 1 — slave select from spi_slave_select; active-low
- `sclk_o` out 1 — SPI serial clock
- `receive_sclk_o` out 1 — one-cycle strobe coincident with each sample edge
- `send_sclk_o` out 1 — one-cycle strobe coincident with each shift edge
- `BaudRateDivisor_o` out 12 — `(sppr_i+1) * 2^(spr_i+1)`; to spi_slave_select

## Operation
- Divisor is combinational. Range is 2 (sppr=0, spr=0) to 2048 (sppr=7, spr=7); no overflow in 12 bits. `half = BaudRateDivisor_o >> 1`.
- `enable = !ss_i && (spi_mode_i==00 || (spi_mode_i==01 && !spiswai_i))`.
- State: 12-bit `count`, `sclk_o` register, two strobe registers. There is no explicit FSM; there are two implicit states:
  - **IDLE** (`!enable`)
    - `count` <= 0.
    - `sclk_o` <= `cpol_i`.
    - Strobes <= 0.
  - **RUN** (`enable`)
    - Terminal count is `tc = (count >= half-1)`. Using `>=` guarantees recovery if the divisor shrinks mid-count.
    - If `tc`: `count` <= 0, `sclk_o` <= `~sclk_o`, and exactly one strobe pulses.
    - Otherwise: `count` <= `count+1`, strobes <= 0.
- Edge classification at `tc`:
  - The edge is a leading edge when the current `sclk_o == cpol_i`.
  - `is_sample = leading ^ cpha_i`.
  - CPHA=0: sample on leading edges, shift on trailing edges.
  - CPHA=1: shift on leading edges, sample on trailing edges.
  - `receive_sclk_o` <= `is_sample`; `send_sclk_o` <= `!is_sample`.
- The block does not count bits. Transfer length is set by spi_slave_select, which holds `ss_i` low for `8 * divisor` PCLK cycles, i.e. 16 SCLK edges.
- `sppr_i`, `spr_i`, `cpol_i` and `cpha_i` must be static while `ss_i` is low. If they change anyway, behaviour stays defined by the rules above; no lockup.

## Timing
- Reset (`PRESET_n`=0 at a PCLK edge):
  - `count` = 0, `sclk_o` = `cpol_i`, `receive_sclk_o` = `send_sclk_o` = 0.
  - `BaudRateDivisor_o` follows its inputs even during reset.
- Reset mid-transfer takes effect at the next PCLK edge and overrides `enable`.
- First edge: with `ss_i` sampled low at edge E0, the first `sclk_o` toggle appears `half` cycles after E0. SCLK period is `divisor` PCLK cycles, 50% duty.
- Each strobe is high for exactly one PCLK cycle, the same cycle in which `sclk_o` shows its new level. Consumers act on the PCLK edge that ends that cycle.
- `half` = 1 (divisor 2): `sclk_o` toggles every cycle and a strobe is high every cycle, alternating sample/shift.
- `ss_i` rising or `enable` dropping (e.g. `spiswai_i` asserted in wait mode): at the next edge `sclk_o` returns to `cpol_i` and strobes clear, even mid-period. A truncated final half-period produces no strobe.
- `ss_i` low and `enable` rising in the same cycle: counting starts from 0 with no extra delay.

## Structure
- Shared package `spi_pkg` holds:
  - mode encodings `SPI_RUN=2'b00`, `SPI_WAIT=2'b01`
  - `SPI_DIV_W=12`
  - the divisor function `(sppr+1) << (spr+1)`, which spi_slave_select must also use so the two stages agree
- No sub-module. Divisor decode is one expression; counter, toggle and strobe logic form one clocked process.

## Test plan
- **Basic run, CPOL=0 CPHA=0, divisor 8:** reset, `sppr=3, spr=0` (divisor 8), mode 00, `ss_i` low for 64 cycles.
  - `BaudRateDivisor_o`=8.
  - `sclk_o` toggles every 4 cycles, 16 edges total.
  - `receive_sclk_o` on the 8 rising edges, `send_sclk_o` on the 8 falling edges.
  - After `ss_i` goes high, `sclk_o`=0.
- **CPOL=1 CPHA=1, divisor 2:** `sppr=0, spr=0`.
  - Idle `sclk_o`=1; toggles every cycle.
  - First strobe is `send_sclk_o` (leading/falling edge); strobes then alternate each cycle.
- **Maximum divisor:** `sppr=7, spr=7`.
  - `BaudRateDivisor_o`=2048.
  - First toggle 1024 cycles after `ss_i` falls.
- **Wait mode:**
  - Mode 01 with `spiswai_i`=1, `ss_i` low: `sclk_o` stays at `cpol_i`, no strobes.
  - Deassert `spiswai_i`: toggling starts from `count`=0.
- **Reset mid-transfer:** `PRESET_n`=0 for one cycle at cycle 10 of a divisor-8 run.
  - `sclk_o`=`cpol_i` and strobes are 0 at the next edge.
  - After release, with `ss_i` still low, the first toggle comes 4 cycles later.
- **Stop mode:** mode 10 with `ss_i` low gives no SCLK activity and `BaudRateDivisor_o` still valid.
